// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S slave receiver: synchronised sclk/lrclk/sdi to stereo DW-bit pairs
module i2s_rx #(
  parameter int DW          = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sclk,
  input  logic          lrclk,
  input  logic          sdi,
  output logic [DW-1:0] l_sample,
  output logic [DW-1:0] r_sample,
  output logic          wr_en,
  output logic          short_err
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {WAIT_SYNC, LEFT, RIGHT} state_t;

  state_t               state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync, lrclk_sync, sdi_sync;
  logic                 sclk_s, lrclk_s, sdi_s;
  logic                 sclk_prev, lrclk_prev;
  logic                 rise, boundary;
  logic [DW-1:0]        sr, sr_shift, sr_pad, l_hold, commit_word;
  logic [CW-1:0]        bit_cnt, pad_sh;
  logic                 do_shift, do_clear, do_latch_l, do_commit, do_short;
  logic                 commit_q;

  assign sclk_s   = sclk_sync[SYNC_STAGES-1];
  assign lrclk_s  = lrclk_sync[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync[SYNC_STAGES-1];
  assign rise     = sclk_s & ~sclk_prev;
  assign boundary = lrclk_s != lrclk_prev;
  assign sr_shift = {sr[DW-2:0], sdi_s};
  // Short slots are left-justified: received bits move to the top, zeros below.
  assign pad_sh   = CW'(DW) - bit_cnt;
  assign sr_pad   = sr << pad_sh;

  always_ff @(posedge clk) begin
    if (rst) state_q <= WAIT_SYNC;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    do_shift    = 1'b0;
    do_clear    = 1'b0;
    do_latch_l  = 1'b0;
    do_commit   = 1'b0;
    do_short    = 1'b0;
    commit_word = sr_shift;
    if (rise) begin
      if (boundary) begin
        case (state_q)
          WAIT_SYNC: begin
            if (!lrclk_s) begin
              state_d  = LEFT;
              do_clear = 1'b1;
            end
          end
          LEFT: begin
            state_d    = RIGHT;
            do_clear   = 1'b1;
            do_latch_l = 1'b1;
            do_short   = bit_cnt != CW'(DW);
          end
          RIGHT: begin
            state_d  = LEFT;
            do_clear = 1'b1;
            // A full right word was already committed early on its last bit.
            if (bit_cnt != CW'(DW)) begin
              do_commit   = 1'b1;
              do_short    = 1'b1;
              commit_word = sr_pad;
            end
          end
          default: state_d = WAIT_SYNC;
        endcase
      end else if (state_q != WAIT_SYNC && bit_cnt != CW'(DW)) begin
        do_shift = 1'b1;
        if (state_q == RIGHT && bit_cnt == CW'(DW - 1)) do_commit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync  <= '0;
      lrclk_sync <= '0;
      sdi_sync   <= '0;
      sclk_prev  <= 1'b0;
      lrclk_prev <= 1'b0;
      sr         <= '0;
      bit_cnt    <= '0;
      l_hold     <= '0;
      l_sample   <= '0;
      r_sample   <= '0;
      commit_q   <= 1'b0;
      wr_en      <= 1'b0;
      short_err  <= 1'b0;
    end else begin
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      lrclk_sync <= {lrclk_sync[SYNC_STAGES-2:0], lrclk};
      sdi_sync   <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      sclk_prev  <= sclk_s;
      if (rise) lrclk_prev <= lrclk_s;
      if (do_clear) begin
        sr      <= '0;
        bit_cnt <= '0;
      end else if (do_shift) begin
        sr      <= sr_shift;
        bit_cnt <= bit_cnt + CW'(1);
      end
      if (do_latch_l) l_hold <= sr_pad;
      if (do_commit) begin
        l_sample <= l_hold;
        r_sample <= commit_word;
      end
      commit_q  <= do_commit;
      wr_en     <= commit_q;
      short_err <= do_short;
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - directed vector bench for i2s_rx driven by an I2S master BFM
module tb_i2s_rx;

  localparam int DW = 24;
  localparam int HB = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sclk = 1'b0;
  logic          lrclk = 1'b0;
  logic          sdi = 1'b0;
  logic [DW-1:0] l_sample, r_sample;
  logic          wr_en, short_err;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int short_cnt = 0;
  logic [DW-1:0] last_l = '0;
  logic [DW-1:0] last_r = '0;

  typedef struct {
    logic [31:0]   l;
    logic [31:0]   r;
    int            n;
    logic [DW-1:0] el;
    logic [DW-1:0] er;
    int            esh;
  } vec_t;

  vec_t vecs[7];

  i2s_rx #(.DW(DW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .lrclk(lrclk), .sdi(sdi),
    .l_sample(l_sample), .r_sample(r_sample), .wr_en(wr_en), .short_err(short_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      wr_cnt = wr_cnt + 1;
      last_l = l_sample;
      last_r = r_sample;
    end
    if (short_err) short_cnt = short_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // The boundary rise carries a dummy trailing bit; data bits follow on later rises.
  task automatic boundary(input logic lr);
    sclk = 1'b0; lrclk = lr; sdi = 1'b0; #HB;
    sclk = 1'b1; #HB;
  endtask

  task automatic slot(input logic lr, input logic [31:0] data, input int n);
    if (lrclk != lr) boundary(lr);
    for (int i = n - 1; i >= 0; i--) begin
      sclk = 1'b0; sdi = data[i]; #HB;
      sclk = 1'b1; #HB;
    end
  endtask

  task automatic settle();
    repeat (12) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{32'hA5A5A5,   32'h5A5A5A,   24, 24'hA5A5A5, 24'h5A5A5A, 0};
    vecs[1] = '{32'h000001,   32'hFFFFFE,   24, 24'h000001, 24'hFFFFFE, 0};
    vecs[2] = '{32'h0000BEEF, 32'h00001234, 16, 24'hBEEF00, 24'h123400, 2};
    vecs[3] = '{32'hCAFEF00D, 32'h12345678, 32, 24'hCAFEF0, 24'h123456, 0};
    vecs[4] = '{32'h0,        32'h0,         0, 24'h000000, 24'h000000, 2};
    vecs[5] = '{32'hA5,       32'h3C,        8, 24'hA50000, 24'h3C0000, 2};
    vecs[6] = '{32'h800000,   32'h7FFFFF,   24, 24'h800000, 24'h7FFFFF, 0};

    repeat (5) @(posedge clk);
    #1;
    chk("reset_l_sample", 32'(l_sample), 32'h0);
    chk("reset_r_sample", 32'(r_sample), 32'h0);
    chk("reset_wr_en", 32'(wr_en), 32'h0);
    chk("reset_short_err", 32'(short_err), 32'h0);
    rst = 1'b0;

    // Right slot before any left start must not produce output.
    slot(1'b1, 32'h123456, 24);
    settle();
    chk("no_out_before_sync", 32'(wr_cnt), 32'd0);

    for (int v = 0; v < 7; v++) begin
      int w0;
      int s0;
      w0 = wr_cnt;
      s0 = short_cnt;
      slot(1'b0, vecs[v].l, vecs[v].n);
      slot(1'b1, vecs[v].r, vecs[v].n);
      boundary(1'b0);
      settle();
      chk($sformatf("v%0d_wr_en_count", v), 32'(wr_cnt - w0), 32'd1);
      chk($sformatf("v%0d_l_sample", v), 32'(last_l), 32'(vecs[v].el));
      chk($sformatf("v%0d_r_sample", v), 32'(last_r), 32'(vecs[v].er));
      chk($sformatf("v%0d_short_err_count", v), 32'(short_cnt - s0), 32'(vecs[v].esh));
    end

    // Reset mid left word: outputs clear, partial frame is discarded.
    begin
      int w0;
      slot(1'b0, 32'hFFF, 12);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      #1;
      chk("midrst_l_zero", 32'(l_sample), 32'h0);
      chk("midrst_r_zero", 32'(r_sample), 32'h0);
      w0 = wr_cnt;
      slot(1'b0, 32'hFFF, 12);
      slot(1'b1, 32'h777777, 24);
      settle();
      chk("midrst_no_partial_pair", 32'(wr_cnt - w0), 32'd0);
      slot(1'b0, 32'h13579B, 24);
      slot(1'b1, 32'h2468AC, 24);
      settle();
      chk("midrst_first_pair_count", 32'(wr_cnt - w0), 32'd1);
      chk("midrst_first_pair_l", 32'(last_l), 32'h13579B);
      chk("midrst_first_pair_r", 32'(last_r), 32'h2468AC);
    end

    // Static clocks: nothing moves.
    begin
      int w0;
      int s0;
      w0 = wr_cnt;
      s0 = short_cnt;
      repeat (300) @(posedge clk);
      #1;
      chk("static_no_wr_en", 32'(wr_cnt - w0), 32'd0);
      chk("static_no_short", 32'(short_cnt - s0), 32'd0);
      chk("static_hold_r", 32'(r_sample), 32'h2468AC);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
